iob_timer_alarm: RTL and testbench

- Downstream consumer of the 64-bit free-running timer value produced by the timer core.
- Compares the live timer value against a programmable 64-bit deadline and raises a sticky interrupt on expiry.
- Supports one-shot and periodic modes; periodic mode auto-reloads by adding a period to the deadline.
- Counts missed expiries. Control pulses come from the peripheral's software register block.

---
 rtl/iob_timer_alarm.sv | 113 +++++++++++
 tb/tb_iob_timer_alarm.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_timer_alarm.sv
// Deadline alarm on the 64-bit free-running timer: one-shot or periodic expiry,
// sticky interrupt, and a saturating count of expiries that land while irq_o is still pending.
module iob_timer_alarm #(
  parameter int TIME_W = 64,
  parameter int MISS_W = 8
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic [TIME_W-1:0] timer_value_i,
  input  logic [TIME_W-1:0] cmp_i,
  input  logic              cmp_load_i,
  input  logic [TIME_W-1:0] period_i,
  input  logic              periodic_i,
  input  logic              arm_i,
  input  logic              disarm_i,
  input  logic              irq_ack_i,
  output logic              armed_o,
  output logic              irq_o,
  output logic              match_o,
  output logic [MISS_W-1:0] missed_o,
  output logic [TIME_W-1:0] cmp_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};
  localparam logic [MISS_W-1:0] MISS_ONE = {{(MISS_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [TIME_W-1:0] r_cmp;
  logic              r_armed;
  logic              r_irq;
  logic              r_match;
  logic [MISS_W-1:0] r_missed;

  logic [TIME_W-1:0] w_diff;
  logic              w_exp;
  logic              w_fire;
  logic              w_reload;
  state_t            w_state_nxt;

  // Wrap-safe expiry test and next-state decode; disarm beats both expiry and arm.
  always_comb begin
    w_diff      = timer_value_i - r_cmp;
    w_exp       = (r_state == ST_ARMED) && !w_diff[TIME_W-1];
    w_fire      = w_exp && !disarm_i;
    // A zero period would re-fire forever, so it degrades to one-shot.
    w_reload    = w_fire && periodic_i && (period_i != {TIME_W{1'b0}});
    w_state_nxt = r_state;
    if (disarm_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arm_i) begin
            w_state_nxt = ST_ARMED;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (w_fire && !w_reload) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_ARMED;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, deadline, interrupt and miss counter; everything freezes while cke_i is low.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state  <= ST_IDLE;
      r_cmp    <= {TIME_W{1'b0}};
      r_armed  <= 1'b0;
      r_irq    <= 1'b0;
      r_match  <= 1'b0;
      r_missed <= {MISS_W{1'b0}};
    end else if (cke_i) begin
      r_state <= w_state_nxt;
      r_armed <= (w_state_nxt == ST_ARMED);
      r_match <= w_fire;
      if (cmp_load_i) begin
        r_cmp <= cmp_i;
      end else if (w_reload) begin
        r_cmp <= r_cmp + period_i;
      end
      if (w_fire) begin
        r_irq <= 1'b1;
      end else if (irq_ack_i) begin
        r_irq <= 1'b0;
      end
      // An ack arriving with the expiry means software is keeping up: not a miss.
      if (w_fire && r_irq && !irq_ack_i && (r_missed != MISS_MAX)) begin
        r_missed <= r_missed + MISS_ONE;
      end
    end
  end

  assign armed_o  = r_armed;
  assign irq_o    = r_irq;
  assign match_o  = r_match;
  assign missed_o = r_missed;
  assign cmp_o    = r_cmp;

endmodule

// File: tb/tb_iob_timer_alarm.sv
// Randomized plus directed bench for iob_timer_alarm: a driver pushes the reference
// model's expected outputs into a queue and a separate monitor pops and compares them.
module tb_iob_timer_alarm;

  typedef struct packed {
    logic        armed;
    logic        irq;
    logic        match;
    logic [7:0]  missed;
    logic [63:0] cmp;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic        cke_i = 1'b0;
  logic [63:0] timer_value_i = 64'd0;
  logic [63:0] cmp_i = 64'd0;
  logic        cmp_load_i = 1'b0;
  logic [63:0] period_i = 64'd0;
  logic        periodic_i = 1'b0;
  logic        arm_i = 1'b0;
  logic        disarm_i = 1'b0;
  logic        irq_ack_i = 1'b0;
  logic        armed_o;
  logic        irq_o;
  logic        match_o;
  logic [7:0]  missed_o;
  logic [63:0] cmp_o;

  iob_timer_alarm #(.TIME_W(64), .MISS_W(8)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i),
    .timer_value_i(timer_value_i), .cmp_i(cmp_i), .cmp_load_i(cmp_load_i),
    .period_i(period_i), .periodic_i(periodic_i), .arm_i(arm_i),
    .disarm_i(disarm_i), .irq_ack_i(irq_ack_i), .armed_o(armed_o),
    .irq_o(irq_o), .match_o(match_o), .missed_o(missed_o), .cmp_o(cmp_o)
  );

  always #5 clk_i = ~clk_i;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  // stimulus settings held between ticks
  logic [63:0] tv = 64'd0;
  logic [63:0] cmpv = 64'd0;
  logic [63:0] perv = 64'd0;
  bit          perm = 1'b0;
  bit          ckev = 1'b1;

  // reference model state
  bit          m_armed = 1'b0;
  bit          m_irq = 1'b0;
  bit          m_match = 1'b0;
  int          m_missed = 0;
  logic [63:0] m_cmp = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_irq = 1'b0; m_match = 1'b0; m_missed = 0; m_cmp = 64'd0;
  endtask

  // Drive one cycle's inputs, advance the model by that edge, queue the result.
  task automatic apply(input bit a, input bit d, input bit k, input bit l);
    bit expired, fire, reload;
    exp_t e;
    cke_i = ckev; timer_value_i = tv; cmp_i = cmpv; period_i = perv;
    periodic_i = perm; arm_i = a; disarm_i = d; irq_ack_i = k; cmp_load_i = l;
    if (ckev) begin
      expired = m_armed && ((tv - m_cmp) < 64'h8000_0000_0000_0000);
      fire    = expired && !d;
      reload  = fire && perm && (perv != 64'd0);
      if (fire && m_irq && !k) m_missed = (m_missed >= 255) ? 255 : m_missed + 1;
      if (fire) m_irq = 1'b1;
      else if (k) m_irq = 1'b0;
      if (l) m_cmp = cmpv;
      else if (reload) m_cmp = m_cmp + perv;
      if (d) m_armed = 1'b0;
      else if (!m_armed) m_armed = a;
      else if (fire && !reload) m_armed = 1'b0;
      m_match = fire;
    end
    e.armed = m_armed; e.irq = m_irq; e.match = m_match;
    e.missed = 8'(m_missed); e.cmp = m_cmp;
    exp_q.push_back(e);
  endtask

  task automatic tick(input bit a, input bit d, input bit k, input bit l);
    @(negedge clk_i);
    apply(a, d, k, l);
  endtask

  task automatic settle();
    @(posedge clk_i);
    #2;
  endtask

  // Async reset in the low clock phase, checked immediately, released before the next edge.
  task automatic do_reset();
    @(negedge clk_i);
    #2 arst_n_i = 1'b0;
    #1;
    chk("async_reset_outputs", {armed_o, irq_o, match_o, missed_o, cmp_o}, 64'd0);
    model_reset();
    #1 arst_n_i = 1'b1;
    ckev = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    ckev = 1'b1;
  endtask

  // Monitor: compare every post-edge output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if ({armed_o, irq_o, match_o, missed_o, cmp_o} !== e) begin
          n_fail++;
          $display("FAIL cycle t=%0t: got armed=%0b irq=%0b match=%0b missed=%0d cmp=%0h, expected armed=%0b irq=%0b match=%0b missed=%0d cmp=%0h",
                   $time, armed_o, irq_o, match_o, missed_o, cmp_o,
                   e.armed, e.irq, e.match, e.missed, e.cmp);
        end
      end
    end
  end

  initial begin
    #1;
    chk("reset_state", {armed_o, irq_o, match_o, missed_o, cmp_o}, 64'd0);
    #1 arst_n_i = 1'b1;

    // one-shot at 100
    cmpv = 64'd100; tv = 64'd0;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t <= 120; t++) begin
      tv = 64'(t);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    settle();
    chk("oneshot_irq", 64'(irq_o), 64'd1);
    chk("oneshot_armed", 64'(armed_o), 64'd0);
    chk("oneshot_cmp", cmp_o, 64'd100);

    // periodic 100/150/200 with ack
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    perm = 1'b1; perv = 64'd50; tv = 64'd0;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    for (int t = 0; t <= 210; t++) begin
      tv = 64'(t);
      tick(1'b0, 1'b0, m_irq, 1'b0);
    end
    settle();
    chk("periodic_cmp", cmp_o, 64'd250);
    chk("periodic_missed", 64'(missed_o), 64'd0);

    // wrap-around, one-shot at 5
    perm = 1'b0; cmpv = 64'd5;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    tv = 64'hFFFF_FFFF_FFFF_FFF0;
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0);
      tv = tv + 64'd1;
    end
    settle();
    chk("wrap_irq", 64'(irq_o), 64'd1);
    chk("wrap_armed", 64'(armed_o), 64'd0);

    // ack with expiry in the same cycle (irq already pending)
    cmpv = 64'd50; tv = 64'd40;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    for (int t = 41; t <= 50; t++) begin
      tv = 64'(t);
      tick(1'b0, 1'b0, (t == 50), 1'b0);
    end
    settle();
    chk("ack_expiry_irq", 64'(irq_o), 64'd1);
    chk("ack_expiry_missed", 64'(missed_o), 64'd0);

    // disarm with expiry
    cmpv = 64'd70;
    tick(1'b1, 1'b0, 1'b1, 1'b1);
    for (int t = 60; t <= 70; t++) begin
      tv = 64'(t);
      tick(1'b0, (t == 70), 1'b0, 1'b0);
    end
    settle();
    chk("disarm_expiry_match", 64'(match_o), 64'd0);
    chk("disarm_expiry_armed", 64'(armed_o), 64'd0);

    // periodic with zero period behaves as one-shot
    perm = 1'b1; perv = 64'd0; cmpv = 64'd80;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    for (int t = 75; t <= 85; t++) begin
      tv = 64'(t);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    settle();
    chk("zero_period_armed", 64'(armed_o), 64'd0);

    // async reset mid-operation with missed=3, then rearm
    do_reset();
    perm = 1'b1; perv = 64'd1; cmpv = 64'd10; tv = 64'd1000;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("pre_reset_missed", 64'(missed_o), 64'd3);
    chk("pre_reset_armed", 64'(armed_o), 64'd1);
    do_reset();
    perm = 1'b0; cmpv = 64'd1005;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int t = 1000; t <= 1008; t++) begin
      tv = 64'(t);
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // saturation: expiry every cycle, never acked
    perm = 1'b1; perv = 64'd1; cmpv = 64'd10; tv = 64'd1000;
    tick(1'b0, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    chk("sat_missed", 64'(missed_o), 64'd255);
    chk("sat_irq", 64'(irq_o), 64'd1);

    // randomized traffic
    do_reset();
    tv = 64'd5000;
    for (int i = 0; i < 600; i++) begin
      bit a, d, k, l;
      ckev = ($urandom_range(0, 9) != 0);
      tv   = tv + 64'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) perm = ~perm;
      if ($urandom_range(0, 7) == 0) perv = 64'($urandom_range(0, 8));
      cmpv = tv + 64'($urandom_range(0, 40));
      a = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 19) == 0);
      k = ($urandom_range(0, 3) == 0);
      l = ($urandom_range(0, 9) == 0);
      tick(a, d, k, l);
    end
    ckev = 1'b1;

    repeat (2) @(posedge clk_i);
    #2;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
